// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch with one outstanding request,
// a small prefetch FIFO and a ready/toggle-trigger downstream interface.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2  // power of two, 2..8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        ackIn,
  output logic        readyOut,
  output logic [31:0] dataOut,
  output logic        triggerOut
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               req_q, req_d;
  logic               drop_q, drop_d;
  logic               trig_q, trig_d;
  logic               ready_q, ready_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem_q [DEPTH];

  logic resp;
  logic push;
  logic pop;
  logic out_after;

  // A response only counts against an outstanding request; branch wins over push/pop.
  assign resp      = imem_valid && req_q;
  assign push      = resp && !drop_q && !branch_valid;
  assign pop       = ackIn && (cnt_q != '0) && !branch_valid;
  assign out_after = req_q && !resp;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    req_d   = out_after;
    drop_d  = drop_q;
    trig_d  = trig_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;

    if (branch_valid) begin
      pc_d   = branch_target & 32'hFFFF_FFFC;
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      drop_d = out_after;
    end else begin
      if (resp && drop_q) begin
        drop_d = 1'b0;
      end
      if (push) begin
        wr_d = wr_q + PTR_W'(1);
        pc_d = pc_q + 32'd4;
      end
      if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

      // New head presented: empty->non-empty, or a pop that leaves entries behind.
      if (push && ((cnt_q == '0) || (pop && (cnt_q == CNT_W'(1))))) begin
        data_d = imem_data;
        trig_d = !trig_q;
      end else if (pop && (cnt_q > CNT_W'(1))) begin
        data_d = mem_q[rd_q + PTR_W'(1)];
        trig_d = !trig_q;
      end
    end

    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (cnt_d == DEPTH_C) state_d = BLOCKED;
      BLOCKED: if (cnt_d < DEPTH_C) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // Issue only when count plus outstanding stays within the FIFO.
    if ((state_d == REQ) && !out_after && (cnt_d < DEPTH_C)) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      data_q  <= '0;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
      trig_q  <= 1'b0;
      ready_q <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
      trig_q  <= trig_d;
      ready_q <= (cnt_d != '0);
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_q] <= imem_data;
    end
  end

  assign ready_d    = ready_q;
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign readyOut   = ready_d;
  assign dataOut    = data_q;
  assign triggerOut = trig_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the condition-check/issue stage.
- Holds the PC and issues sequential word requests to instruction memory, one outstanding request at a time.
- Buffers returned instructions in a small prefetch FIFO and presents them downstream on a ready/toggle-trigger interface.
- Redirects on branch by flushing the FIFO and discarding any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, prefetch FIFO entries (power of two, 2..8).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  memory request; held high with imem_addr stable until imem_valid.
- imem_addr  out  32  word address of the request.
- imem_valid  in  1  one-cycle pulse: imem_data valid for the outstanding request.
- imem_data  in  32  returned instruction word.
- branch_valid  in  1  one-cycle redirect pulse.
- branch_target  in  32  redirect PC; bits [1:0] ignored (forced 0).
- ackIn  in  1  one-cycle pulse: downstream consumed the current dataOut.
- readyOut  out  1  high while the FIFO is non-empty.
- dataOut  out  32  FIFO head word.
- triggerOut  out  1  toggles once per newly presented head word.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, FIFO empty, no outstanding request, drop=0. Outputs: imem_req=0, imem_addr=RESET_PC, readyOut=0, dataOut=0, triggerOut=0.
- FSM states: IDLE, REQ, BLOCKED.
  - IDLE: entered only from reset; moves to REQ on the first clock edge after rst deasserts.
  - REQ: imem_req=1, imem_addr=pc.
  - BLOCKED: imem_req=0. Entered when count==DEPTH after a response is written. Returns to REQ on the edge where count drops below DEPTH.
- Issue rule: a new request issues only if (count + outstanding) < DEPTH. The FIFO therefore never overflows.
- Response: on imem_valid with drop=0, push imem_data, pc += 4, and issue the next request from the following cycle if space allows.
  - Address sequence is pc, pc+4, pc+8, ...
  - pc wraps 32'hFFFF_FFFC -> 0 silently.
  - Push-to-readyOut latency: 1 cycle; the word is visible the cycle after the imem_valid edge.
- imem_valid with no outstanding request is ignored.
- Pop: ackIn while readyOut=1 removes the head. ackIn while readyOut=0 is ignored.
- triggerOut toggles on the edge where:
  - the FIFO goes empty -> non-empty, or
  - a pop leaves the FIFO non-empty (a new head is presented).
  - There is exactly one toggle per delivered word. dataOut is updated on that same edge, so it is stable before the toggle is seen.
- Simultaneous pop + push:
  - Both take effect; count is unchanged.
  - When the FIFO held 1 entry, the pushed word becomes the head and triggerOut toggles once.
- Branch (branch_valid=1), highest priority over push/pop in the same cycle:
  - FIFO cleared; readyOut=0 next cycle; no toggle.
  - pc = {branch_target[31:2], 2'b00}.
  - If a request is outstanding: drop=1, and imem_req stays high with the old address until its imem_valid arrives. That response is discarded, drop clears, and the next request uses the new pc.
  - If no request is outstanding: the next cycle requests the target.
- Branch while drop=1: pc is overwritten by the latest target, drop stays 1.
- Reset mid-operation: any in-flight memory response after rst deasserts is ignored because outstanding is 0.
- dataOut holds its last value when the FIFO is empty.

Test Plan:
- Reset and start: rst high 3 cycles, RESET_PC=0x100 -> outputs all 0, imem_addr=0x100. First cycle after release: imem_req=1, addr=0x100.
- Straight-line fetch: 1-cycle memory returns 0xE0000001, 0xE0000002, 0xE0000003; ackIn each cycle -> addresses 0x100/0x104/0x108 in order. dataOut shows each word for one presentation; triggerOut toggles 3 times, readyOut high from the cycle after the first response.
- Backpressure: DEPTH=2, no ackIn -> exactly 2 words buffered, imem_req low (BLOCKED), readyOut=1, single toggle. One ackIn -> dataOut becomes the 2nd word, toggle, and a request to 0x108 issues.
- Branch with request in flight: 3-cycle memory latency, branch_valid to 0x2003 while 0x104 outstanding -> the 0x104 response is discarded. Next request addr=0x2000; FIFO flushed, readyOut=0, no toggle from the discarded word.
- Simultaneous events: ackIn and imem_valid in the same cycle with count=1 -> count stays 1, dataOut is the new word, one toggle. branch_valid + ackIn + imem_valid together -> FIFO empty and pc=target.
- Reset mid-operation: assert rst with 2 words buffered and a request outstanding -> readyOut=0 and imem_req=0 immediately (asynchronous). A stale imem_valid after release is ignored; fetch restarts at RESET_PC.
